// File: rtl/div_pkg.sv
// Shared types and sizing for the multicycle restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Iteration counter must hold values up to WIDTH.
  function automatic int unsigned div_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: produces one quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The extra top bit holds the bit shifted out of rem; diff[WIDTH] is the borrow.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_i};

  assign rem_o = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Multicycle 32-bit divider (div, optionally divu): quotient on lo, remainder on hi.
// Define DIV_UNSIGNED_EN to add the is_unsigned port for divu support.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = div_cnt_w(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] step_rem, step_quo;

`ifdef DIV_UNSIGNED_EN
  assign signed_op = ~is_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  assign a_neg = signed_op & a_in[WIDTH-1];
  assign b_neg = signed_op & b_in[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (b_in == WIDTH'(0)) begin
            dz_d = 1'b1;
          end else begin
            // Work on magnitudes; signs are reapplied in FIX.
            neg_rem_d = a_neg;
            neg_quo_d = a_neg ^ b_neg;
            quo_d     = a_neg ? (WIDTH'(0) - a_in) : a_in;
            dvs_d     = b_neg ? (WIDTH'(0) - b_in) : b_in;
            rem_d     = WIDTH'(0);
            count_d   = CNT_W'(0);
            busy_d    = 1'b1;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = neg_quo_q ? (WIDTH'(0) - quo_q) : quo_q;
        hi_d    = neg_rem_q ? (WIDTH'(0) - rem_q) : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= CNT_W'(0);
      rem_q     <= WIDTH'(0);
      quo_q     <= WIDTH'(0);
      dvs_q     <= WIDTH'(0);
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= WIDTH'(0);
      lo_q      <= WIDTH'(0);
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; define DIV_UNSIGNED_EN to also cover divu.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef DIV_UNSIGNED_EN
  logic        is_unsigned;
`endif

  int errors = 0;
  int checks = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef DIV_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start a division right before the next edge and follow it to done.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input bit inject);
    int  n;
    bit  dz_seen;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ":busy_e0"}, 32'(busy), 32'd1);
    dz_seen = div_zero;
    n = 0;
    while (!done && n < 45) begin
      if (inject && n == 5) begin
        a_in  = 32'd100;
        b_in  = 32'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      dz_seen = dz_seen | div_zero;
    end
    start = 1'b0;
    chk({tag, ":latency"}, 32'(n), 32'd33);
    chk({tag, ":lo"}, lo, exp_lo);
    chk({tag, ":hi"}, hi, exp_hi);
    chk({tag, ":busy_done"}, 32'(busy), 32'd0);
    chk({tag, ":div_zero"}, 32'(dz_seen), 32'd0);
  endtask

  initial begin
    bit done_seen;
    reset = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
`ifdef DIV_UNSIGNED_EN
    is_unsigned = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:div_zero", 32'(div_zero), 32'd0);
    chk("rst:hi", hi, 32'd0);
    chk("rst:lo", lo, 32'd0);

    run_div("7/2", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
    @(posedge clk); #1;
    chk("7/2:done_one_cycle", 32'(done), 32'd0);
    run_div("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_div("-7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);
    run_div("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);

    // Divide by zero: one-cycle flag, no done, result registers untouched.
    a_in  = 32'd5;
    b_in  = 32'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dz:flag", 32'(div_zero), 32'd1);
    chk("dz:busy", 32'(busy), 32'd0);
    done_seen = done;
    @(posedge clk); #1;
    chk("dz:flag_drop", 32'(div_zero), 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
      done_seen = done_seen | done;
    end
    chk("dz:no_done", 32'(done_seen), 32'd0);
    chk("dz:lo_kept", lo, 32'hFFFF_FFFD);
    chk("dz:hi_kept", hi, 32'hFFFF_FFFF);

    run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    // Start while done is high is accepted immediately.
    run_div("b2b_9/4", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

    // Reset mid-calculation clears outputs asynchronously.
    a_in  = 32'd100;
    b_in  = 32'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid:busy", 32'(busy), 32'd0);
    chk("rst_mid:hi", hi, 32'd0);
    chk("rst_mid:lo", lo, 32'd0);
    chk("rst_mid:done", 32'(done), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      done_seen = done_seen | done;
    end
    chk("rst_mid:no_done", 32'(done_seen), 32'd0);

    // A second start mid-run (100/3) must be ignored.
    run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);

`ifdef DIV_UNSIGNED_EN
    @(posedge clk); #1;
    is_unsigned = 1'b1;
    run_div("divu", 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0);
    is_unsigned = 1'b0;
    run_div("div_s", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multicycle 32-bit integer divider for the MIPS multicycle CPU, implementing `div` (and optionally `divu`). It consumes the register-file A/B operands latched by the datapath and is started by the control unit's `DivCtrl` pulse. It produces quotient (LO) and remainder (HI) for the Hi/Lo register write, and flags division by zero to the control unit for the exception path (`ExCause`). It is a restoring shift-subtract engine with one quotient bit per cycle.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; the CPU instantiates it at 32.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  `DivCtrl`; sampled only in IDLE.
- `a_in`  in  WIDTH  dividend (register rs).
- `b_in`  in  WIDTH  divisor (register rt).
- `busy`  out  1  high while a division is in flight.
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold the new result.
- `div_zero`  out  1  one-cycle pulse; divisor was zero.
- `hi`  out  WIDTH  remainder.
- `lo`  out  WIDTH  quotient.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with `start=1` and `b_in!=0`:
  - Latch sign(a), sign(b) and |a|, |b| as unsigned magnitudes.
  - Clear the partial remainder and set `count=0`.
  - Go to CALC and set `busy`.
- IDLE with `start=1` and `b_in==0`:
  - Pulse `div_zero` for one cycle and stay in IDLE.
  - `hi`/`lo` stay unchanged; `done` is not asserted.
- CALC, each cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract |b| from rem in WIDTH+1 bits.
  - If the result is non-negative, keep it and set quo LSB=1; otherwise restore rem and set quo LSB=0.
  - After WIDTH iterations, go to FIX.
- FIX:
  - `lo` = quo, negated if sign(a)≠sign(b).
  - `hi` = rem, negated if sign(a)=1. This truncates toward zero; the remainder takes the dividend's sign.
  - Set `done`, clear `busy`, return to IDLE.
- 0x80000000 / −1 is not special-cased. It yields `lo`=0x80000000, `hi`=0 with no flag.
- `start` while busy is ignored. Operands are captured only at the accepting edge, so later `a_in`/`b_in` changes have no effect.
- `start` in the cycle `done` is high is accepted, because the FSM is already in IDLE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, count=0.
- `start` is accepted at edge E0. CALC runs at edges E1..E_WIDTH. FIX at E_WIDTH+1 registers `hi`/`lo` and `done`.
- `done` is high from E_WIDTH+1 to E_WIDTH+2 (edges 33→34 for WIDTH=32).
- Total latency is WIDTH+1 cycles from the accepting edge.
- `busy` is high from E0 to E_WIDTH+1.
- `div_zero` is high from E0 to E1.
- `hi`/`lo` hold their value until the next FIX or reset.
- Reset mid-CALC aborts immediately: all outputs return to reset values and no `done` pulse is produced.

## Configuration
- `DIV_UNSIGNED_EN`: defined, adds port `is_unsigned  in  1`, sampled with `start`.
  - When 1, sign extraction and fix-up negation are bypassed (`divu`).
  - The zero check is unchanged.
- Undefined: the port does not exist and all divisions are signed.

## Structure
- Package `div_pkg`:
  - state enum {IDLE, CALC, FIX}.
  - `DIV_WIDTH`=32.
  - count width $clog2(WIDTH+1).
- Sub-module `div_step`: combinational single iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once in `div_unit`.

## Test plan
- `a`=7, `b`=2, start → `done` at edge 33; `lo`=3, `hi`=1; `busy` low afterwards.
- `a`=−7 (0xFFFFFFF9), `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- `a`=0x80000000, `b`=0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_zero`=0.
- `a`=5, `b`=0 → `div_zero` pulse for exactly one cycle; no `done`; prior `hi`/`lo` retained.
- Start 100/7, assert `reset` at cycle 10 → `busy`/`hi`/`lo`=0 immediately. A new start of 100/7 then gives `lo`=14, `hi`=2. A second `start` issued mid-run (100/3) is ignored.
- With `DIV_UNSIGNED_EN`: 0xFFFFFFFF/2, `is_unsigned`=1 → `lo`=0x7FFFFFFF, `hi`=1. The same operands with `is_unsigned`=0 give `lo`=0, `hi`=0xFFFFFFFF.
